// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect request and IF/ID
// outputs toward decode. master = fetch stage, slave = memory/decode/control side.
interface fetch_if #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [PC_W-1:0]   imem_a;
    logic [DATA_W-1:0] imem_rd;
    logic              redir_valid;
    logic [PC_W-1:0]   redir_pc;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [PC_W-1:0]   id_pc;
    logic [PC_W-1:0]   id_pc1;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              halted;

    modport master (
        output imem_a, id_valid, id_instr, id_pc, id_pc1, fetch_cnt, halted,
        input  imem_rd, redir_valid, redir_pc, id_ready
    );

    modport slave (
        input  imem_a, id_valid, id_instr, id_pc, id_pc1, fetch_cnt, halted,
        output imem_rd, redir_valid, redir_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register with valid/ready backpressure and redirect flush.
// Optional self-loop halt detection when FETCH_HALT_DET_EN is defined.
module fetch_stage #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32,
    parameter int unsigned     DATA_W   = 32
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]   pc_reg;
    logic [PC_W-1:0]   pc_next;
    logic              id_valid_reg;
    logic [DATA_W-1:0] id_instr_reg;
    logic [PC_W-1:0]   id_pc_reg;
    logic [PC_W-1:0]   id_pc1_reg;
    logic [CNT_W-1:0]  fetch_cnt_reg;
    logic              halted;
    logic              adv;
    logic              redir_take;

    assign pc_next    = pc_reg + PC_ONE;
    assign adv        = !halted && (!id_valid_reg || bus.id_ready);
    assign redir_take = !halted && bus.redir_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            id_valid_reg  <= 1'b0;
            id_instr_reg  <= '0;
            id_pc_reg     <= '0;
            id_pc1_reg    <= '0;
            fetch_cnt_reg <= '0;
        end else if (redir_take) begin
            // Flush wins over a stalled decode; the stale IF/ID word is dropped.
            pc_reg       <= bus.redir_pc;
            id_valid_reg <= 1'b0;
        end else if (adv) begin
            id_instr_reg  <= bus.imem_rd;
            id_pc_reg     <= pc_reg;
            id_pc1_reg    <= pc_next;
            id_valid_reg  <= 1'b1;
            pc_reg        <= pc_next;
            fetch_cnt_reg <= fetch_cnt_reg + CNT_ONE;
        end else if (halted && bus.id_ready) begin
            id_valid_reg <= 1'b0;
        end
    end

`ifdef FETCH_HALT_DET_EN
    localparam logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'h1000ffff);
    logic halted_reg;

    // Halt is taken on the same edge that the self-loop word enters IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_reg <= 1'b0;
        end else if (adv && !redir_take && (bus.imem_rd == HALT_WORD)) begin
            halted_reg <= 1'b1;
        end
    end
    assign halted = halted_reg;
`else
    assign halted = 1'b0;
`endif

    assign bus.imem_a    = pc_reg;
    assign bus.id_valid  = id_valid_reg;
    assign bus.id_instr  = id_instr_reg;
    assign bus.id_pc     = id_pc_reg;
    assign bus.id_pc1    = id_pc1_reg;
    assign bus.fetch_cnt = fetch_cnt_reg;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a second instance with RESET_PC=FFFF covers PC wrap from reset.
module tb_fetch_stage;
    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
        logic [15:0] pc1;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   halt_armed = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    ent_t        sb[$];
    logic [15:0] m_pc;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic        m_halt;

    fetch_if #(.PC_W(16), .DATA_W(32), .CNT_W(32)) bus();
    fetch_if #(.PC_W(16), .DATA_W(32), .CNT_W(32)) bus2();

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fetch_stage #(.PC_W(16), .RESET_PC(16'hFFFF), .CNT_W(32), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [15:0] a);
        if (halt_armed && a == 16'd3) return 32'h1000ffff;
        return {16'hC0DE, a ^ 16'h5A5A};
    endfunction

    assign bus.imem_rd  = imem_word(bus.imem_a);
    assign bus2.imem_rd = imem_word(bus2.imem_a);
    assign bus2.redir_valid = 1'b0;
    assign bus2.redir_pc    = 16'h0000;
    assign bus2.id_ready    = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_halt_word(input logic [31:0] w);
`ifdef FETCH_HALT_DET_EN
        return w == 32'h1000ffff;
`else
        return 1'b0 && (w == 32'h0);
`endif
    endfunction

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
        m_halt  = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle at the falling edge, check IF/ID against the scoreboard, advance the model.
    task automatic cycle(input logic rv, input logic [15:0] rp, input logic rdy);
        ent_t e;
        bit   adv;
        bus.redir_valid = rv;
        bus.redir_pc    = rp;
        bus.id_ready    = rdy;
        #1;
        check("imem_a", bus.imem_a, m_pc);
        check("id_valid", bus.id_valid, m_valid);
        if (m_valid) begin
            check("sb_depth", sb.size(), 1);
            if (sb.size() != 0) begin
                e = sb[0];
                check("id_instr", bus.id_instr, e.instr);
                check("id_pc", bus.id_pc, e.pc);
                check("id_pc1", bus.id_pc1, e.pc1);
                if (rdy) begin
                    void'(sb.pop_front());
                    $display("xfer pc=%04h pc1=%04h instr=%08h", e.pc, e.pc1, e.instr);
                end else if (!m_halt && rv) begin
                    void'(sb.pop_front());
                end
            end
        end
        adv = !m_halt && (!m_valid || rdy);
        if (!m_halt && rv) begin
            m_pc    = rp;
            m_valid = 1'b0;
        end else if (adv) begin
            e.instr = imem_word(m_pc);
            e.pc    = m_pc;
            e.pc1   = m_pc + 16'd1;
            sb.push_back(e);
            if (is_halt_word(e.instr)) m_halt = 1'b1;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            m_cnt   = m_cnt + 32'd1;
        end else if (m_halt && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("fetch_cnt", bus.fetch_cnt, m_cnt);
        check("halted", bus.halted, m_halt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_a"}, bus.imem_a, 16'h0000);
        check({tag, "_id_valid"}, bus.id_valid, 1'b0);
        check({tag, "_id_instr"}, bus.id_instr, 32'h0);
        check({tag, "_id_pc"}, bus.id_pc, 16'h0000);
        check({tag, "_id_pc1"}, bus.id_pc1, 16'h0000);
        check({tag, "_fetch_cnt"}, bus.fetch_cnt, 32'd0);
        check({tag, "_halted"}, bus.halted, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 16'h0000;
        bus.id_ready    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_dut2_imem_a", bus2.imem_a, 16'hFFFF);
        rst = 1'b0;

        // Sequential fetch; the FFFF instance wraps to 0000 on its second capture.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 1'b1);
            if (i == 0) begin
                check("T4_id_pc", bus2.id_pc, 16'hFFFF);
                check("T4_id_pc1", bus2.id_pc1, 16'h0000);
                check("T4_id_valid", bus2.id_valid, 1'b1);
            end
            if (i == 1) check("T4_wrap_id_pc", bus2.id_pc, 16'h0000);
        end
        check("T1_fetch_cnt", bus.fetch_cnt, 32'd5);
        check("T1_id_pc", bus.id_pc, 16'd4);

        // Backpressure while pc=7 is in IF/ID.
        repeat (3) cycle(1'b0, 16'h0, 1'b1);
        repeat (3) cycle(1'b0, 16'h0, 1'b0);
        check("T2_pc", bus.imem_a, 16'd8);
        check("T2_id_pc", bus.id_pc, 16'd7);
        check("T2_fetch_cnt", bus.fetch_cnt, 32'd8);
        cycle(1'b0, 16'h0, 1'b1);
        check("T2_resume_id_pc", bus.id_pc, 16'd8);

        // Redirect while decode is stalled flushes IF/ID.
        cycle(1'b1, 16'h0026, 1'b0);
        check("T3_id_valid", bus.id_valid, 1'b0);
        check("T3_pc", bus.imem_a, 16'h0026);
        cycle(1'b0, 16'h0, 1'b1);
        check("T3_id_pc", bus.id_pc, 16'h0026);

        // PC wrap in the main instance, and refetch of the current pc.
        cycle(1'b1, 16'hFFFE, 1'b1);
        repeat (4) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, bus.imem_a, 1'b0);
        repeat (2) cycle(1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            cycle(($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Async reset in the middle of a stall with IF/ID full.
        cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0);
        check("T6_pre_valid", bus.id_valid, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("T6");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b1);
        check("T6_resume_id_pc", bus.id_pc, 16'h0000);
        repeat (3) cycle(1'b0, 16'h0, 1'b1);

`ifdef FETCH_HALT_DET_EN
        halt_armed = 1'b1;
        cycle(1'b1, 16'h0000, 1'b0);
        repeat (6) cycle(1'b0, 16'h0, 1'b1);
        check("T5_halted", bus.halted, 1'b1);
        check("T5_pc", bus.imem_a, 16'd4);
        cycle(1'b1, 16'h0055, 1'b0);
        check("T5_redir_ignored", bus.imem_a, 16'd4);
        repeat (2) cycle(1'b0, 16'h0, 1'b1);
        check("T5_drained", bus.id_valid, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
